// File: rtl/hazard_scoreboard.sv
// Scoreboard-based ID hazard unit: tracks in-flight GPR writes per stage,
// derives ID stall, rs/rt forwarding selects and a saturating stall counter.
module hazard_scoreboard #(
   parameter int DEPTH = 3,
   parameter int AW    = 5,
   parameter int TW    = 2,
   parameter int SELW  = 2,
   parameter int CW    = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [AW-1:0]   id_rs,
   input  logic [AW-1:0]   id_rt,
   input  logic [TW-1:0]   id_tuse_rs,
   input  logic [TW-1:0]   id_tuse_rt,
   input  logic            id_regwrite,
   input  logic [AW-1:0]   id_a3,
   input  logic [TW-1:0]   id_tnew,
   input  logic            id_is_md,
   input  logic            kill,
   input  logic            md_busy,
   input  logic            md_start,
   output logic            stall,
   output logic [SELW-1:0] fwd_rs_sel,
   output logic [SELW-1:0] fwd_rt_sel,
   output logic [CW-1:0]   stall_cnt
);

   localparam logic [TW-1:0] TINF = '1;

   logic [DEPTH:1]  v_q, v_d;
   logic [AW-1:0]   a3_q [DEPTH:1];
   logic [AW-1:0]   a3_d [DEPTH:1];
   logic [TW-1:0]   tn_q [DEPTH:1];
   logic [TW-1:0]   tn_d [DEPTH:1];
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [SELW-1:0] rs_sel, rt_sel;
   logic [TW-1:0]   rs_tn, rt_tn;
   logic            data_rs, data_rt, md_stall;

   // Scan oldest to youngest so the nearest writer overrides older ones.
   always_comb begin
      rs_sel = '0;
      rt_sel = '0;
      rs_tn  = '0;
      rt_tn  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         if (v_q[k] && (a3_q[k] == id_rs) && (id_rs != '0)) begin
            rs_sel = SELW'(k);
            rs_tn  = tn_q[k];
         end
         if (v_q[k] && (a3_q[k] == id_rt) && (id_rt != '0)) begin
            rt_sel = SELW'(k);
            rt_tn  = tn_q[k];
         end
      end
   end

   assign data_rs  = (rs_sel != '0) && (id_tuse_rs != TINF)
                     && (rs_tn > id_tuse_rs);
   assign data_rt  = (rt_sel != '0) && (id_tuse_rt != TINF)
                     && (rt_tn > id_tuse_rt);
   assign md_stall = id_is_md & (md_busy | md_start);

   assign stall      = id_valid & ~kill & (data_rs | data_rt | md_stall);
   assign fwd_rs_sel = rs_sel;
   assign fwd_rt_sel = rt_sel;
   assign stall_cnt  = cnt_q;

   always_comb begin
      v_d[1]  = id_valid & id_regwrite & (id_a3 != '0) & ~stall & ~kill;
      a3_d[1] = id_a3;
      tn_d[1] = id_tnew;
      for (int k = 2; k <= DEPTH; k++) begin
         v_d[k]  = v_q[k-1];
         a3_d[k] = a3_q[k-1];
         tn_d[k] = (tn_q[k-1] != '0) ? tn_q[k-1] - TW'(1) : '0;
      end
      cnt_d = (stall && (cnt_q != '1)) ? cnt_q + CW'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q   <= '0;
         cnt_q <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            a3_q[k] <= '0;
            tn_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         cnt_q <= cnt_d;
         for (int k = 1; k <= DEPTH; k++) begin
            a3_q[k] <= a3_d[k];
            tn_q[k] <= tn_d[k];
         end
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random
// traffic against an issue-history model of the pipeline.
module tb_hazard_scoreboard;

   localparam int D = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic [4:0] id_rs, id_rt, id_a3;
   logic [1:0] id_tuse_rs, id_tuse_rt, id_tnew;
   logic       id_regwrite, id_is_md, kill, md_busy, md_start;
   logic       stall;
   logic [1:0] fwd_rs_sel, fwd_rt_sel;
   logic [15:0] stall_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: what was issued k cycles ago; tnew derived from age.
   bit hv [1:D];
   int ha [1:D];
   int ht [1:D];
   int m_cnt;

   hazard_scoreboard dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs(id_rs), .id_rt(id_rt),
      .id_tuse_rs(id_tuse_rs), .id_tuse_rt(id_tuse_rt),
      .id_regwrite(id_regwrite), .id_a3(id_a3), .id_tnew(id_tnew),
      .id_is_md(id_is_md), .kill(kill),
      .md_busy(md_busy), .md_start(md_start),
      .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int eff_tnew(input int k);
      int t;
      t = ht[k] - (k - 1);
      return (t < 0) ? 0 : t;
   endfunction

   function automatic int m_sel(input int src);
      for (int k = 1; k <= D; k++)
         if (hv[k] && ha[k] == src && src != 0) return k;
      return 0;
   endfunction

   function automatic bit m_data(input int src, input int tuse);
      int k;
      k = m_sel(src);
      if (k == 0 || tuse == 3) return 1'b0;
      return eff_tnew(k) > tuse;
   endfunction

   function automatic bit m_stall();
      bit md;
      md = id_is_md && (md_busy || md_start);
      return id_valid && !kill &&
             (m_data(id_rs, id_tuse_rs) || m_data(id_rt, id_tuse_rt) || md);
   endfunction

   task automatic eval();
      #1;
      chk("stall", stall, m_stall());
      chk("fwd_rs", fwd_rs_sel, m_sel(id_rs));
      chk("fwd_rt", fwd_rt_sel, m_sel(id_rt));
      chk("cnt", stall_cnt, m_cnt);
   endtask

   task automatic adv();
      bit s;
      s = m_stall();
      @(posedge clk);
      if (reset) begin
         for (int k = 1; k <= D; k++) begin
            hv[k] = 0; ha[k] = 0; ht[k] = 0;
         end
         m_cnt = 0;
      end else begin
         if (s && m_cnt < 65535) m_cnt++;
         for (int k = D; k >= 2; k--) begin
            hv[k] = hv[k-1]; ha[k] = ha[k-1]; ht[k] = ht[k-1];
         end
         hv[1] = id_valid && id_regwrite && id_a3 != 0 && !s && !kill;
         ha[1] = id_a3;
         ht[1] = id_tnew;
      end
      @(negedge clk);
   endtask

   task automatic set_id(input bit v, input int rs, input int tur,
                         input int rt, input int tut, input bit rw,
                         input int a3, input int tn, input bit md);
      id_valid = v; id_rs = 5'(rs); id_tuse_rs = 2'(tur);
      id_rt = 5'(rt); id_tuse_rt = 2'(tut); id_regwrite = rw;
      id_a3 = 5'(a3); id_tnew = 2'(tn); id_is_md = md;
   endtask

   task automatic idle(input int n);
      set_id(0, 0, 3, 0, 3, 0, 0, 0, 0);
      kill = 0; md_busy = 0; md_start = 0;
      for (int i = 0; i < n; i++) begin
         eval();
         adv();
      end
   endtask

   int c0;

   initial begin
      for (int k = 1; k <= D; k++) begin
         hv[k] = 0; ha[k] = 0; ht[k] = 0;
      end
      m_cnt = 0;
      reset = 1;
      set_id(0, 0, 3, 0, 3, 0, 0, 0, 0);
      kill = 0; md_busy = 0; md_start = 0;
      @(negedge clk);
      adv();
      reset = 0;
      eval();
      chk("rst_stall", stall, 0);
      chk("rst_cnt", stall_cnt, 0);
      adv();

      // load-use
      set_id(1, 0, 3, 0, 3, 1, 8, 2, 0); eval(); adv();
      set_id(1, 8, 1, 0, 3, 1, 9, 1, 0); eval();
      chk("lu_stall", stall, 1); adv();
      eval();
      chk("lu_stall2", stall, 0);
      chk("lu_fwd", fwd_rs_sel, 2); adv();
      idle(3);

      // branch after ALU op
      set_id(1, 0, 3, 0, 3, 1, 3, 1, 0); eval(); adv();
      set_id(1, 3, 0, 3, 0, 0, 0, 0, 0); eval();
      chk("br_stall", stall, 1); adv();
      eval();
      chk("br_stall2", stall, 0);
      chk("br_fwd_rs", fwd_rs_sel, 2);
      chk("br_fwd_rt", fwd_rt_sel, 2); adv();
      idle(3);

      // shadowing
      set_id(1, 0, 3, 0, 3, 1, 5, 1, 0); eval(); adv();
      set_id(1, 0, 3, 0, 3, 1, 5, 0, 0); eval(); adv();
      set_id(1, 5, 0, 0, 3, 0, 0, 0, 0); eval();
      chk("sh_fwd", fwd_rs_sel, 1);
      chk("sh_stall", stall, 0); adv();
      idle(3);

      // register zero
      set_id(1, 0, 3, 0, 3, 1, 0, 2, 0); eval(); adv();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 0); eval();
      chk("z_stall", stall, 0);
      chk("z_fwd", fwd_rs_sel, 0); adv();
      idle(3);

      // mult/div busy
      c0 = stall_cnt;
      md_busy = 1;
      set_id(1, 1, 0, 2, 0, 1, 4, 0, 0); eval();
      chk("md_addu", stall, 0); adv();
      set_id(1, 0, 3, 0, 3, 1, 6, 0, 1);
      for (int i = 0; i < 3; i++) begin
         eval();
         chk("md_mfhi", stall, 1); adv();
      end
      md_busy = 0; eval();
      chk("md_free", stall, 0); adv();
      chk("md_cnt", stall_cnt - c0, 3);
      idle(3);

      // kill
      set_id(1, 0, 3, 0, 3, 1, 8, 2, 0); eval(); adv();
      set_id(1, 8, 1, 0, 3, 1, 9, 1, 0); kill = 1; eval();
      chk("k_stall", stall, 0); adv();
      kill = 0;
      set_id(1, 9, 0, 0, 3, 0, 0, 0, 0); eval();
      chk("k_fwd", fwd_rs_sel, 0); adv();
      idle(3);

      // reset with a full scoreboard
      for (int r = 1; r <= 3; r++) begin
         set_id(1, 0, 3, 0, 3, 1, r, 3, 0); eval(); adv();
      end
      set_id(1, 1, 0, 2, 0, 0, 0, 0, 0); eval(); adv();
      reset = 1; eval(); adv();
      reset = 0; eval();
      chk("r_stall", stall, 0);
      chk("r_fwd_rs", fwd_rs_sel, 0);
      chk("r_fwd_rt", fwd_rt_sel, 0);
      chk("r_cnt", stall_cnt, 0); adv();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         set_id($urandom_range(0, 3) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 1), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3) == 0);
         kill     = $urandom_range(0, 7) == 0;
         md_busy  = $urandom_range(0, 3) == 0;
         md_start = $urandom_range(0, 7) == 0;
         reset    = $urandom_range(0, 63) == 0;
         eval();
         adv();
      end
      reset = 0;
      idle(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
